// File: rtl/cpu5_lsu.sv
// Load/store unit: one core memory op -> one granted, split-response bus transaction.
// Optional misalignment trap enabled by defining CPU5_LSU_MISALIGN_TRAP_EN.
module cpu5_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            stall,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            misalign,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              misalign_q, misalign_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;

    logic [3:0]        be_new;
    logic [XLEN-1:0]   wdata_new;
    logic [4:0]        shamt;
    logic [XLEN-1:0]   rd_shift;
    logic [XLEN-1:0]   load_ext;

    // Lane selection for the incoming request; size 2'b11 behaves as a word.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = req_wdata;
        case (req_size)
            2'b00: begin
                be_new    = 4'b0001 << req_addr[1:0];
                wdata_new = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {req_addr[1], 1'b0};
                wdata_new = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load alignment uses the size/offset captured at issue, not the live request.
    always_comb begin
        shamt = 5'd0;
        case (size_q)
            2'b00:   shamt = {off_q, 3'b000};
            2'b01:   shamt = {off_q[1], 4'b0000};
            default: shamt = 5'd0;
        endcase
        rd_shift = bus_rdata >> shamt;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'd0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_ext = uns_q ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        misalign_d  = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d   = req_we;
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    off_d  = req_addr[1:0];
`ifdef CPU5_LSU_MISALIGN_TRAP_EN
                    if ((req_size == 2'b01 && req_addr[0]) ||
                        (req_size[1] && req_addr[1:0] != 2'b00)) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        misalign_d  = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d     = S_REQ;
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_we;
                        bus_addr_d  = {req_addr[XLEN-1:2], 2'b00};
                        bus_be_d    = be_new;
                        bus_wdata_d = wdata_new;
                    end
`else
                    state_d     = S_REQ;
                    bus_req_d   = 1'b1;
                    bus_we_d    = req_we;
                    bus_addr_d  = {req_addr[XLEN-1:2], 2'b00};
                    bus_be_d    = be_new;
                    bus_wdata_d = wdata_new;
`endif
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    state_d   = S_WAIT;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    cnt_d     = '0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_rvalid) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus_err;
                    rsp_rdata_d = (we_q || bus_err) ? '0 : load_ext;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            misalign_q  <= 1'b0;
            rsp_rdata_q <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            misalign_q  <= misalign_d;
            rsp_rdata_q <= rsp_rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    // The core may advance only in the cycle the response is presented.
    assign stall     = req_valid & (state_q != S_RESP);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign misalign  = misalign_q;
    assign rsp_rdata = rsp_rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_cpu5_lsu.sv
// Bench for cpu5_lsu: directed ops, expected bus requests and responses queued and
// compared by independent monitors. Honours CPU5_LSU_MISALIGN_TRAP_EN like the design.
module tb_cpu5_lsu;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        misalign;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [68:0] bus_q[$];  // {we, be, addr, wdata}
    logic [33:0] rsp_q[$];  // {misalign, err, rdata}
    logic        bus_req_prev;

    cpu5_lsu #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .misalign(misalign),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, need done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, need 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_bus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bus_q.push_back({we, be, addr, wdata});
    endtask

    task automatic exp_rsp(input logic [31:0] rdata, input logic err, input logic mis);
        rsp_q.push_back({mis, err, rdata});
    endtask

    // Bus monitor: each new request is compared to the oldest expected request.
    always @(negedge clk) begin
        if (!reset && bus_req && !bus_req_prev) begin
            vec_cnt++;
            if (bus_q.size() == 0) begin
                err_cnt++;
                $display("FAIL bus_unexpected: got addr 0x%08h be %b, need no request", bus_addr, bus_be);
            end else begin
                logic [68:0] e;
                e = bus_q.pop_front();
                if ({bus_we, bus_be, bus_addr, bus_wdata} !== e) begin
                    err_cnt++;
                    $display("FAIL bus_req: got we %b be %b addr 0x%08h wdata 0x%08h, need we %b be %b addr 0x%08h wdata 0x%08h",
                             bus_we, bus_be, bus_addr, bus_wdata, e[68], e[67:64], e[63:32], e[31:0]);
                end
            end
        end
        bus_req_prev <= bus_req;
    end

    // Response monitor.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            vec_cnt++;
            if (rsp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL rsp_unexpected: got rdata 0x%08h err %b, need no response", rsp_rdata, rsp_err);
            end else begin
                logic [33:0] e;
                e = rsp_q.pop_front();
                if ({misalign, rsp_err, rsp_rdata} !== e) begin
                    err_cnt++;
                    $display("FAIL rsp: got mis %b err %b rdata 0x%08h, need mis %b err %b rdata 0x%08h",
                             misalign, rsp_err, rsp_rdata, e[33], e[32], e[31:0]);
                end
            end
        end
    end

    // Drives one core op and plays the bus slave: grant after gnt_dly extra REQ cycles,
    // read response rv_dly cycles into WAIT (or never when respond=0).
    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int gnt_dly, input int rv_dly, input logic respond,
                          input logic [31:0] rdata, input logic berr,
                          input int exp_stall, input int exp_req, input string name);
        int stall_n = 0;
        int req_n   = 0;
        int wcyc    = 0;
        int cyc     = 0;
        bit granted = 0;
        bit done    = 0;
        @(posedge clk);
        #1;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        while (!done && cyc < 100) begin
            @(negedge clk);
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            bus_err    = 1'b0;
            if (stall) stall_n++;
            if (rsp_valid) begin
                done      = 1;
                req_valid = 1'b0;
            end else if (bus_req) begin
                req_n++;
                if (req_n == gnt_dly + 1) begin
                    bus_gnt = 1'b1;
                    granted = 1;
                end
            end else if (granted) begin
                if (respond && wcyc == rv_dly) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rdata;
                    bus_err    = berr;
                    granted    = 0;
                end
                wcyc++;
            end
            cyc++;
        end
        if (!done) begin
            req_valid = 1'b0;
            bus_gnt   = 1'b0;
            bus_rvalid = 1'b0;
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_stall_cycles"}, 32'(stall_n), 32'(exp_stall));
        chk({name, "_req_cycles"}, 32'(req_n), 32'(exp_req));
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        bus_gnt      = 1'b0;
        bus_rvalid   = 1'b0;
        bus_rdata    = '0;
        bus_err      = 1'b0;
        bus_req_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_req",   32'(bus_req), 32'd0);
        chk("rst_bus_we",    32'(bus_we), 32'd0);
        chk("rst_bus_be",    32'(bus_be), 32'd0);
        chk("rst_bus_addr",  bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err), 32'd0);
        chk("rst_misalign",  32'(misalign), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_stall",     32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // LW, immediate grant, response next cycle.
        exp_bus(1'b0, 4'b1111, 32'h100, 32'h0);
        exp_rsp(32'hDEADBEEF, 1'b0, 1'b0);
        run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 0, 1'b1, 32'hDEADBEEF, 1'b0, 3, 1, "lw");

        // LB / LBU at the top byte lane.
        exp_bus(1'b0, 4'b1000, 32'h100, 32'h0);
        exp_rsp(32'hFFFFFF80, 1'b0, 1'b0);
        run_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 0, 1'b1, 32'h80112233, 1'b0, 3, 1, "lb");
        exp_bus(1'b0, 4'b1000, 32'h100, 32'h0);
        exp_rsp(32'h00000080, 1'b0, 1'b0);
        run_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 0, 1'b1, 32'h80112233, 1'b0, 3, 1, "lbu");

        // SH with grant held off three cycles.
        exp_bus(1'b1, 4'b1100, 32'h200, 32'hABCDABCD);
        exp_rsp(32'h0, 1'b0, 1'b0);
        run_op(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 3, 0, 1'b1, 32'h12345678, 1'b0, 6, 4, "sh");

        // Half loads, upper signed and lower unsigned.
        exp_bus(1'b0, 4'b1100, 32'h100, 32'h0);
        exp_rsp(32'hFFFF8001, 1'b0, 1'b0);
        run_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 1, 1'b1, 32'h80017FFF, 1'b0, 4, 1, "lh_hi");
        exp_bus(1'b0, 4'b0011, 32'h100, 32'h0);
        exp_rsp(32'h00008765, 1'b0, 1'b0);
        run_op(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 0, 0, 1'b1, 32'h12348765, 1'b0, 3, 1, "lhu_lo");

        // SB lane 1, SW, and size 11 treated as word.
        exp_bus(1'b1, 4'b0010, 32'h100, 32'h78787878);
        exp_rsp(32'h0, 1'b0, 1'b0);
        run_op(1'b1, 2'b00, 1'b0, 32'h101, 32'h12345678, 1, 0, 1'b1, 32'hFFFFFFFF, 1'b0, 4, 2, "sb");
        exp_bus(1'b1, 4'b1111, 32'h300, 32'hCAFEF00D);
        exp_rsp(32'h0, 1'b0, 1'b0);
        run_op(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D, 0, 0, 1'b1, 32'h0, 1'b0, 3, 1, "sw");
        exp_bus(1'b0, 4'b1111, 32'h800, 32'h0);
        exp_rsp(32'h01020304, 1'b0, 1'b0);
        run_op(1'b0, 2'b11, 1'b0, 32'h800, 32'h0, 0, 0, 1'b1, 32'h01020304, 1'b0, 3, 1, "lw_sz3");

        // Bus error response forces zero data.
        exp_bus(1'b0, 4'b1111, 32'h400, 32'h0);
        exp_rsp(32'h0, 1'b1, 1'b0);
        run_op(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 0, 2, 1'b1, 32'h00000055, 1'b1, 5, 1, "lw_berr");

        // Timeout after 4 WAIT cycles, then a late rvalid that must be ignored.
        exp_bus(1'b0, 4'b1111, 32'h500, 32'h0);
        exp_rsp(32'h0, 1'b1, 1'b0);
        run_op(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0, 6, 1, "lw_timeout");
        @(negedge clk);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h11111111;
        @(negedge clk);
        bus_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_rvalid_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end

        // Misaligned half.
`ifdef CPU5_LSU_MISALIGN_TRAP_EN
        exp_rsp(32'h0, 1'b1, 1'b1);
        run_op(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 0, 0, 1'b1, 32'h0000F00F, 1'b0, 1, 0, "lh_mis");
`else
        exp_bus(1'b0, 4'b0011, 32'h100, 32'h0);
        exp_rsp(32'hFFFFF00F, 1'b0, 1'b0);
        run_op(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 0, 0, 1'b1, 32'h0000F00F, 1'b0, 3, 1, "lh_mis");
`endif

        // Reset while waiting for the response.
        exp_bus(1'b0, 4'b1111, 32'h700, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h700;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_req_seen", 32'(bus_req), 32'd1);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_bus_req", 32'(bus_req), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_rsp_err", 32'(rsp_err), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        reset      = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h22222222;
        @(negedge clk);
        bus_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("post_rst_bus_req", 32'(bus_req), 32'd0);
            @(negedge clk);
        end

        exp_bus(1'b0, 4'b1111, 32'h600, 32'h0);
        exp_rsp(32'h13579BDF, 1'b0, 1'b0);
        run_op(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 0, 0, 1'b1, 32'h13579BDF, 1'b0, 3, 1, "lw_after_rst");

        repeat (3) @(negedge clk);
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
